// File: rtl/trace_buffer.sv
// Commit trace buffer: circular store of retired instructions with show-ahead read.
// Define TRACE_TSTAMP_EN to attach a 32-bit capture-cycle timestamp to each record.
module trace_buffer #(
    parameter int CH    = 2,
    parameter int DEPTH = 16,
    parameter int WRAP  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   stop,
    input  logic                   clear,
    input  logic [CH-1:0]          cm_valid,
    input  logic [32*CH-1:0]       cm_pc,
    input  logic [32*CH-1:0]       cm_inst,
    input  logic [CH-1:0]          cm_rdv,
    input  logic [5*CH-1:0]        cm_rd,
    input  logic [32*CH-1:0]       cm_rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [31:0]            rd_pc,
    output logic [31:0]            rd_inst,
    output logic [31:0]            rd_rdata,
    output logic [4:0]             rd_rd,
    output logic                   rd_rdv,
    output logic [31:0]            rd_tstamp,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 2;
    localparam bit WRAP_EN = (WRAP != 0);
    localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_DIS = 2'b00,
        S_CAP = 2'b01,
        S_FRZ = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;

    logic [31:0] pc_q    [DEPTH];
    logic [31:0] inst_q  [DEPTH];
    logic [31:0] rdata_q [DEPTH];
    logic [4:0]  rd_q    [DEPTH];
    logic        rdv_q   [DEPTH];

    logic          pop, cap;
    logic [SW-1:0] room, acc, lost, level, ovw;
    logic [16:0]   dsum;
    logic [CH-1:0] wr_en;
    logic [AW-1:0] wr_addr [CH];

    assign rd_valid = (count_q != '0);

    always_comb begin
        pop     = rd_valid && rd_ready;
        cap     = reset && !clear && (state_q == S_CAP);
        room    = DEPTH_W - SW'(count_q) + SW'(pop);
        acc     = '0;
        lost    = '0;
        wr_en   = '0;
        for (int c = 0; c < CH; c++) begin
            wr_addr[c] = tail_q;
            if (cap && cm_valid[c]) begin
                // Lower channels claim free slots first when not wrapping.
                if (WRAP_EN || acc < room) begin
                    wr_en[c]   = 1'b1;
                    wr_addr[c] = tail_q + acc[AW-1:0];
                    acc        = acc + SW'(1);
                end else begin
                    lost = lost + SW'(1);
                end
            end
        end
        level = SW'(count_q) - SW'(pop) + acc;
        ovw   = (WRAP_EN && level > DEPTH_W) ? level - DEPTH_W : '0;
        lost  = lost + ovw;

        count_d    = level[AW:0] - ovw[AW:0];
        head_d     = head_q + AW'(pop) + ovw[AW-1:0];
        tail_d     = tail_q + acc[AW-1:0];
        dsum       = {1'b0, drop_q} + 17'(lost);
        drop_d     = dsum[16] ? 16'hFFFF : dsum[15:0];
        overflow_d = overflow_q || (lost != '0);

        state_d = state_q;
        unique case (state_q)
            S_DIS: if (en) state_d = S_CAP;
            S_CAP: begin
                if (stop) state_d = S_FRZ;
                else if (!WRAP_EN && count_d == DEPTH_C) state_d = S_FRZ;
                else if (!en) state_d = S_DIS;
            end
            S_FRZ: state_d = S_FRZ;
            default: state_d = S_DIS;
        endcase

        if (clear) begin
            state_d    = S_DIS;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_DIS;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (wr_en[c]) begin
                pc_q[wr_addr[c]]    <= cm_pc[32*c +: 32];
                inst_q[wr_addr[c]]  <= cm_inst[32*c +: 32];
                rdv_q[wr_addr[c]]   <= cm_rdv[c];
                rd_q[wr_addr[c]]    <= cm_rdv[c] ? cm_rd[5*c +: 5] : 5'd0;
                rdata_q[wr_addr[c]] <= cm_rdv[c] ? cm_rd_data[32*c +: 32] : 32'd0;
            end
        end
    end

`ifdef TRACE_TSTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] tsm_q [DEPTH];

    assign ts_d = ts_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_d;
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (wr_en[c]) tsm_q[wr_addr[c]] <= ts_q;
        end
    end

    assign rd_tstamp = tsm_q[head_q];
`else
    assign rd_tstamp = '0;
`endif

    assign rd_pc    = pc_q[head_q];
    assign rd_inst  = inst_q[head_q];
    assign rd_rdata = rdata_q[head_q];
    assign rd_rd    = rd_q[head_q];
    assign rd_rdv   = rdv_q[head_q];
    assign count    = count_q;
    assign state    = state_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: directed table, corner sequences and random traffic
// against a queue model, on a stop-when-full and a wrapping instance.
module tb_trace_buffer;

    localparam int CH = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, en, stop, clear, rd_ready;
    logic [1:0]  cm_valid, cm_rdv;
    logic [63:0] cm_pc, cm_inst, cm_rd_data;
    logic [9:0]  cm_rd;

    logic        rv_o   [2];
    logic [31:0] pc_o   [2];
    logic [31:0] inst_o [2];
    logic [31:0] dat_o  [2];
    logic [31:0] ts_o   [2];
    logic [4:0]  rd_o   [2];
    logic        rdv_o  [2];
    logic [2:0]  cnt_o  [2];
    logic [1:0]  st_o   [2];
    logic        ovf_o  [2];
    logic [15:0] drop_o [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    trace_buffer #(.CH(CH), .DEPTH(DEPTH), .WRAP(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .stop(stop), .clear(clear),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_rdv(cm_rdv), .cm_rd(cm_rd), .cm_rd_data(cm_rd_data),
        .rd_valid(rv_o[0]), .rd_ready(rd_ready), .rd_pc(pc_o[0]),
        .rd_inst(inst_o[0]), .rd_rdata(dat_o[0]), .rd_rd(rd_o[0]),
        .rd_rdv(rdv_o[0]), .rd_tstamp(ts_o[0]), .count(cnt_o[0]),
        .state(st_o[0]), .overflow(ovf_o[0]), .drop_cnt(drop_o[0])
    );

    trace_buffer #(.CH(CH), .DEPTH(DEPTH), .WRAP(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .stop(stop), .clear(clear),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_rdv(cm_rdv), .cm_rd(cm_rd), .cm_rd_data(cm_rd_data),
        .rd_valid(rv_o[1]), .rd_ready(rd_ready), .rd_pc(pc_o[1]),
        .rd_inst(inst_o[1]), .rd_rdata(dat_o[1]), .rd_rd(rd_o[1]),
        .rd_rdv(rdv_o[1]), .rd_tstamp(ts_o[1]), .count(cnt_o[1]),
        .state(st_o[1]), .overflow(ovf_o[1]), .drop_cnt(drop_o[1])
    );

    typedef struct {
        logic [31:0] pc, inst, rdata, ts;
        logic [4:0]  rd;
        logic        rdv;
    } rec_t;

    rec_t        mq [2][$];
    int          mst [2] = '{0, 0};
    int          mdrop [2] = '{0, 0};
    bit          movf [2] = '{0, 0};
    logic [31:0] mts = '0;

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int lost = 0;
            if (!reset || clear) begin
                mq[d].delete();
                mst[d] = 0;
                mdrop[d] = 0;
                movf[d] = 0;
                continue;
            end
            if (mq[d].size() > 0 && rd_ready) void'(mq[d].pop_front());
            if (mst[d] == 1) begin
                for (int c = 0; c < CH; c++) begin
                    if (cm_valid[c]) begin
                        rec_t r;
                        r.pc = cm_pc[32*c +: 32];
                        r.inst = cm_inst[32*c +: 32];
                        r.rdv = cm_rdv[c];
                        r.rd = cm_rdv[c] ? cm_rd[5*c +: 5] : 5'd0;
                        r.rdata = cm_rdv[c] ? cm_rd_data[32*c +: 32] : 32'd0;
`ifdef TRACE_TSTAMP_EN
                        r.ts = mts;
`else
                        r.ts = 32'd0;
`endif
                        if (d == 1) begin
                            mq[d].push_back(r);
                            if (mq[d].size() > DEPTH) begin
                                void'(mq[d].pop_front());
                                lost++;
                            end
                        end else if (mq[d].size() < DEPTH) begin
                            mq[d].push_back(r);
                        end else begin
                            lost++;
                        end
                    end
                end
                mdrop[d] = (mdrop[d] + lost > 65535) ? 65535 : mdrop[d] + lost;
                if (lost > 0) movf[d] = 1;
                if (stop) mst[d] = 2;
                else if (d == 0 && mq[d].size() == DEPTH) mst[d] = 2;
                else if (!en) mst[d] = 0;
            end else if (mst[d] == 0 && en) begin
                mst[d] = 1;
            end
        end
        mts = reset ? mts + 32'd1 : 32'd0;
    endtask

    task automatic check_dut(int d);
        logic [22:0]  got, exp;
        logic [133:0] hg, he;
        rec_t         h;
        total++;
        exp = {mq[d].size() != 0, 3'(mq[d].size()), 2'(mst[d]),
               movf[d], 16'(mdrop[d])};
        got = {rv_o[d], cnt_o[d], st_o[d], ovf_o[d], drop_o[d]};
        if (got !== exp) begin
            bad++;
            $display("FAIL dut%0d status {rv,cnt,st,ovf,drop} got=%h want=%h",
                     d, got, exp);
        end
        if (mq[d].size() > 0) begin
            h = mq[d][0];
            total++;
            he = {h.pc, h.inst, h.rdata, h.ts, h.rd, h.rdv};
            hg = {pc_o[d], inst_o[d], dat_o[d], ts_o[d], rd_o[d], rdv_o[d]};
            if (hg !== he) begin
                bad++;
                $display("FAIL dut%0d head got=%h want=%h", d, hg, he);
            end
        end
    endtask

    task automatic step(bit chk);
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk) begin
            check_dut(0);
            check_dut(1);
        end
    endtask

    task automatic set_in(logic r, logic e, logic s, logic c, logic [1:0] v,
                          logic [31:0] p0, logic [31:0] p1, logic rdy);
        reset = r;
        en = e;
        stop = s;
        clear = c;
        cm_valid = v;
        cm_pc = {p1, p0};
        cm_inst = {~p1, ~p0};
        cm_rdv = v;
        cm_rd = {5'd2, 5'd1};
        cm_rd_data = {p1 + 32'd1, p0 + 32'd1};
        rd_ready = rdy;
    endtask

    typedef struct {
        logic        rst, en, stop, clr;
        logic [1:0]  v;
        logic [31:0] p0, p1;
        logic        rdy;
        logic [2:0]  c0;
        logic [1:0]  s0;
        logic [15:0] d0;
        logic [31:0] h0;
        logic [2:0]  c1;
        logic [1:0]  s1;
        logic [15:0] d1;
        logic [31:0] h1;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic r, logic e, logic s, logic c,
                                logic [1:0] v, logic [31:0] p0, logic [31:0] p1,
                                logic rdy, int c0, int s0, int d0,
                                logic [31:0] h0, int c1, int s1, int d1,
                                logic [31:0] h1);
        vec_t t;
        t.rst = r; t.en = e; t.stop = s; t.clr = c; t.v = v;
        t.p0 = p0; t.p1 = p1; t.rdy = rdy;
        t.c0 = 3'(c0); t.s0 = 2'(s0); t.d0 = 16'(d0); t.h0 = h0;
        t.c1 = 3'(c1); t.s1 = 2'(s1); t.d1 = 16'(d1); t.h1 = h1;
        return t;
    endfunction

    task automatic check_vec(int i, int d, logic [2:0] ec, logic [1:0] es,
                             logic [15:0] ed, logic [31:0] eh);
        logic [21:0] got, exp;
        total++;
        got = {cnt_o[d], st_o[d], drop_o[d], ovf_o[d]};
        exp = {ec, es, ed, ed != 16'd0};
        if (got !== exp) begin
            bad++;
            $display("FAIL vec%0d dut%0d {cnt,st,drop,ovf} got=%h want=%h",
                     i, d, got, exp);
        end
        total++;
        if (rv_o[d] !== (ec != 3'd0) || (ec != 3'd0 && pc_o[d] !== eh)) begin
            bad++;
            $display("FAIL vec%0d dut%0d head rv=%b pc=%h want rv=%b pc=%h",
                     i, d, rv_o[d], pc_o[d], ec != 3'd0, eh);
        end
    endtask

    initial begin
        logic [31:0] want_ts;
        tbl[0]  = mk(0,0,0,0,0,0,0,0,         0,0,0,0,       0,0,0,0);
        tbl[1]  = mk(1,1,0,0,0,0,0,0,         0,1,0,0,       0,1,0,0);
        tbl[2]  = mk(1,1,0,0,3,'h100,'h104,0, 2,1,0,'h100,   2,1,0,'h100);
        tbl[3]  = mk(1,1,0,0,0,0,0,1,         1,1,0,'h104,   1,1,0,'h104);
        tbl[4]  = mk(1,1,0,0,3,'h108,'h10c,0, 3,1,0,'h104,   3,1,0,'h104);
        tbl[5]  = mk(1,1,0,0,3,'h110,'h114,0, 4,2,1,'h104,   4,1,1,'h108);
        tbl[6]  = mk(1,1,0,1,0,0,0,0,         0,0,0,0,       0,0,0,0);
        tbl[7]  = mk(1,1,0,0,0,0,0,0,         0,1,0,0,       0,1,0,0);
        tbl[8]  = mk(1,1,0,0,1,'h0,0,0,       1,1,0,0,       1,1,0,0);
        tbl[9]  = mk(1,1,0,0,1,'h4,0,0,       2,1,0,0,       2,1,0,0);
        tbl[10] = mk(1,1,0,0,1,'h8,0,0,       3,1,0,0,       3,1,0,0);
        tbl[11] = mk(1,1,0,0,1,'hc,0,0,       4,2,0,0,       4,1,0,0);
        tbl[12] = mk(1,1,0,0,1,'h10,0,0,      4,2,0,0,       4,1,1,'h4);
        tbl[13] = mk(1,1,0,0,1,'h14,0,0,      4,2,0,0,       4,1,2,'h8);
        tbl[14] = mk(1,1,0,1,0,0,0,0,         0,0,0,0,       0,0,0,0);
        tbl[15] = mk(1,1,0,0,0,0,0,0,         0,1,0,0,       0,1,0,0);
        tbl[16] = mk(1,1,1,0,1,'h200,0,0,     1,2,0,'h200,   1,2,0,'h200);
        tbl[17] = mk(1,1,0,0,3,'h300,'h304,0, 1,2,0,'h200,   1,2,0,'h200);
        tbl[18] = mk(1,1,0,1,0,0,0,0,         0,0,0,0,       0,0,0,0);
        tbl[19] = mk(1,1,0,0,0,0,0,0,         0,1,0,0,       0,1,0,0);
        tbl[20] = mk(1,1,0,0,3,'h10,'h14,0,   2,1,0,'h10,    2,1,0,'h10);
        tbl[21] = mk(1,1,0,0,1,'h18,0,0,      3,1,0,'h10,    3,1,0,'h10);
        tbl[22] = mk(0,1,0,0,3,'h20,'h24,1,   0,0,0,0,       0,0,0,0);
        tbl[23] = mk(1,1,0,0,0,0,0,0,         0,1,0,0,       0,1,0,0);
        tbl[24] = mk(1,1,0,0,1,'h40,0,0,      1,1,0,'h40,    1,1,0,'h40);

        for (int i = 0; i < 25; i++) begin
            set_in(tbl[i].rst, tbl[i].en, tbl[i].stop, tbl[i].clr,
                   tbl[i].v, tbl[i].p0, tbl[i].p1, tbl[i].rdy);
            step(1);
            check_vec(i, 0, tbl[i].c0, tbl[i].s0, tbl[i].d0, tbl[i].h0);
            check_vec(i, 1, tbl[i].c1, tbl[i].s1, tbl[i].d1, tbl[i].h1);
        end

        // Timestamp of a commit five cycles after reset release.
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, 0, 0, 0, 0, 0, 0);
            step(1);
        end
        set_in(1, 1, 0, 0, 1, 'h500, 0, 0);
        step(1);
`ifdef TRACE_TSTAMP_EN
        want_ts = 32'd5;
`else
        want_ts = 32'd0;
`endif
        total++;
        if (ts_o[1] !== want_ts || pc_o[1] !== 32'h500) begin
            bad++;
            $display("FAIL tstamp got=%0d pc=%h want=%0d pc=500",
                     ts_o[1], pc_o[1], want_ts);
        end

        // Drive the wrapping instance until the loss counter saturates.
        set_in(1, 1, 0, 1, 0, 0, 0, 0);
        step(1);
        for (int i = 0; i < 33000; i++) begin
            set_in(1, 1, 0, 0, 3, 32'(4 * i), 32'(4 * i + 2), 0);
            step(0);
        end
        set_in(1, 1, 0, 0, 3, 'h900, 'h904, 0);
        step(1);
        total++;
        if (drop_o[1] !== 16'hffff || ovf_o[1] !== 1'b1 || st_o[1] !== 2'b01) begin
            bad++;
            $display("FAIL drop_sat drop=%h ovf=%b st=%b want ffff 1 01",
                     drop_o[1], ovf_o[1], st_o[1]);
        end

        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        step(1);
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom % 150) != 0;
            clear = ($urandom % 60) == 0;
            stop = ($urandom % 40) == 0;
            en = ($urandom % 10) != 0;
            cm_valid = 2'($urandom);
            cm_rdv = 2'($urandom);
            cm_pc = {$urandom, $urandom};
            cm_inst = {$urandom, $urandom};
            cm_rd = 10'($urandom);
            cm_rd_data = {$urandom, $urandom};
            rd_ready = ($urandom % 3) == 0;
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
